// File: rtl/apb_fsm_controller.sv
// APB sequencing FSM for the AHB-to-APB bridge.
// Turns each accepted AHB transfer into one SETUP + ENABLE pair on APB and
// drives Hreadyout low during SETUP so the AHB master waits for the APB side.
// Back-to-back writes reuse the pipelined address/data copies (Haddr1/Haddr2,
// Hwdata/Hwdata1) so that no transfer is dropped while the previous one completes.

module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic [NSLV-1:0]   tempselx,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_e;

    state_e              state_q,     state_d;
    logic [NSLV-1:0]     pselx_q,     pselx_d;
    logic [NSLV-1:0]     selxHold_q,  selxHold_d;
    logic                penable_q,   penable_d;
    logic                pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic                hreadyout_q, hreadyout_d;

    // Remember the decoded slave of the latest write address phase; the write
    // SETUP happens one or more cycles later, when tempselx already follows a
    // newer address.
    assign selxHold_d = (valid && Hwrite) ? tempselx : selxHold_q;

    // Next-state logic: reads go straight to SETUP, writes wait a cycle for data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (valid && Hwrite)       state_d = ST_WWAIT;
                else if (valid && !Hwrite) state_d = ST_READ;
                else                       state_d = ST_IDLE;
            end
            ST_WWAIT: begin
                if (valid) state_d = ST_WRITEP;
                else       state_d = ST_WRITE;
            end
            ST_READ: begin
                state_d = ST_RENABLE;
            end
            ST_WRITE: begin
                if (valid) state_d = ST_WENABLEP;
                else       state_d = ST_WENABLE;
            end
            ST_WRITEP: begin
                state_d = ST_WENABLEP;
            end
            ST_RENABLE, ST_WENABLE: begin
                if (valid && !Hwrite)     state_d = ST_READ;
                else if (valid && Hwrite) state_d = ST_WWAIT;
                else                      state_d = ST_IDLE;
            end
            ST_WENABLEP: begin
                if (Hwritereg && valid)       state_d = ST_WRITEP;
                else if (Hwritereg && !valid) state_d = ST_WRITE;
                else                          state_d = ST_READ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next values, chosen by the state being entered so every APB and
    // Hreadyout signal comes straight from a flop.
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;
        case (state_d)
            ST_READ: begin
                pselx_d     = tempselx;
                paddr_d     = Haddr;
                pwrite_d    = 1'b0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                pselx_d     = selxHold_q;
                pwrite_d    = 1'b1;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = Haddr2;
                    pwdata_d = Hwdata1;
                end else begin
                    paddr_d  = Haddr1;
                    pwdata_d = Hwdata;
                end
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_d   = 1'b1;
                hreadyout_d = 1'b1;
            end
            ST_IDLE, ST_WWAIT: begin
                if (state_q != ST_IDLE || state_d != ST_IDLE) begin
                    pselx_d     = '0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                end
            end
            default: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
        endcase
    end

    // State and output registers; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            selxHold_q  <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            selxHold_q  <= selxHold_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Testbench for apb_fsm_controller: directed AHB-side vectors with
// hand-computed APB outputs, checked cycle by cycle through a scoreboard queue.

module tb_apb_fsm_controller;

    typedef struct {
        string       name;
        int          cyc;
        logic [2:0]  sel;
        logic        en;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
    } exp_t;

    logic        clk;
    logic        rstN;
    logic        validIn;
    logic        hwriteIn;
    logic        hwriteRegIn;
    logic [31:0] haddrIn;
    logic [31:0] haddr1In;
    logic [31:0] haddr2In;
    logic [31:0] hwdataIn;
    logic [31:0] hwdata1In;
    logic [2:0]  tempSelIn;
    logic [2:0]  pselxOut;
    logic        penableOut;
    logic        pwriteOut;
    logic [31:0] paddrOut;
    logic [31:0] pwdataOut;
    logic        hreadyOut;

    int   numChecks;
    int   numPassed;
    int   cycleCount;
    exp_t expQ[$];

    apb_fsm_controller #(
        .ADDR_W(32),
        .DATA_W(32),
        .NSLV(3)
    ) dut (
        .clk       (clk),
        .rst       (rstN),
        .valid     (validIn),
        .Hwrite    (hwriteIn),
        .Hwritereg (hwriteRegIn),
        .Haddr     (haddrIn),
        .Haddr1    (haddr1In),
        .Haddr2    (haddr2In),
        .Hwdata    (hwdataIn),
        .Hwdata1   (hwdata1In),
        .tempselx  (tempSelIn),
        .Pselx     (pselxOut),
        .Penable   (penableOut),
        .Pwrite    (pwriteOut),
        .Paddr     (paddrOut),
        .Pwdata    (pwdataOut),
        .Hreadyout (hreadyOut)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle stamp so each expectation is checked after exactly the right edge.
    always @(posedge clk) begin
        cycleCount++;
    end

    function automatic exp_t mkExp(input string name, input logic [2:0] sel, input logic en,
                                   input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic rdy);
        exp_t e;
        e.name  = name;
        e.cyc   = 0;
        e.sel   = sel;
        e.en    = en;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdy   = rdy;
        return e;
    endfunction

    function automatic void checkOutput(input exp_t e);
        numChecks++;
        if ({pselxOut, penableOut, pwriteOut, paddrOut, pwdataOut, hreadyOut} !==
            {e.sel, e.en, e.wr, e.addr, e.wdata, e.rdy}) begin
            $display("[TB] FAIL %s: got sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b, want sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b",
                     e.name, pselxOut, penableOut, pwriteOut, paddrOut, pwdataOut, hreadyOut,
                     e.sel, e.en, e.wr, e.addr, e.wdata, e.rdy);
        end else begin
            numPassed++;
        end
    endfunction

    // Drive one cycle of AHB-side inputs and queue the outputs expected after the next edge.
    task automatic applyStimulus(input string name, input logic v, input logic w, input logic wreg,
                                 input logic [31:0] a, input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] d, input logic [31:0] d1, input logic [2:0] ts,
                                 input logic [2:0] eSel, input logic eEn, input logic eWr,
                                 input logic [31:0] eAddr, input logic [31:0] eWdata, input logic eRdy);
        exp_t e;
        @(posedge clk);
        #1;
        validIn     = v;
        hwriteIn    = w;
        hwriteRegIn = wreg;
        haddrIn     = a;
        haddr1In    = a1;
        haddr2In    = a2;
        hwdataIn    = d;
        hwdata1In   = d1;
        tempSelIn   = ts;
        e     = mkExp(name, eSel, eEn, eWr, eAddr, eWdata, eRdy);
        e.cyc = cycleCount + 1;
        expQ.push_back(e);
    endtask

    // Monitor: compare the DUT against every expectation due in this cycle.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
            exp_t e;
            e = expQ.pop_front();
            if (e.cyc < cycleCount) begin
                numChecks++;
                $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cycleCount, e.cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        numChecks   = 0;
        numPassed   = 0;
        cycleCount  = 0;
        rstN        = 1'b0;
        validIn     = 1'b0;
        hwriteIn    = 1'b0;
        hwriteRegIn = 1'b0;
        haddrIn     = '0;
        haddr1In    = '0;
        haddr2In    = '0;
        hwdataIn    = '0;
        hwdata1In   = '0;
        tempSelIn   = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput(mkExp("reset_values", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
        rstN = 1'b1;

        // No valid transfer while the address bus toggles: FSM must stay idle.
        applyStimulus("idle_0", 0,0,0, 32'h1234_5678, 0, 0, 32'hAAAA_AAAA, 0, 3'b100,  3'b000,0,0, 32'h0, 32'h0, 1);
        applyStimulus("idle_1", 0,1,0, 32'hFFFF_0000, 0, 0, 32'h5555_5555, 0, 3'b001,  3'b000,0,0, 32'h0, 32'h0, 1);
        applyStimulus("idle_2", 0,0,1, 32'h0F0F_0F0F, 0, 0, 32'h0,         0, 3'b010,  3'b000,0,0, 32'h0, 32'h0, 1);

        // Single read.
        applyStimulus("rd_setup",  1,0,0, 32'h8000_0010, 0, 0, 0, 0, 3'b001,  3'b001,0,0, 32'h8000_0010, 32'h0, 0);
        applyStimulus("rd_enable", 0,0,0, 0, 0, 0, 0, 0, 3'b000,              3'b001,1,0, 32'h8000_0010, 32'h0, 1);
        applyStimulus("rd_idle",   0,0,0, 0, 0, 0, 0, 0, 3'b000,              3'b000,0,0, 32'h8000_0010, 32'h0, 1);

        // Single write.
        applyStimulus("wr_wwait",  1,1,0, 32'h8400_0020, 0, 0, 0, 0, 3'b010,  3'b000,0,0, 32'h8000_0010, 32'h0, 1);
        applyStimulus("wr_setup",  0,0,1, 0, 32'h8400_0020, 0, 32'hDEAD_BEEF, 0, 3'b000,
                      3'b010,0,1, 32'h8400_0020, 32'hDEAD_BEEF, 0);
        applyStimulus("wr_enable", 0,0,0, 0, 0, 0, 0, 0, 3'b000,              3'b010,1,1, 32'h8400_0020, 32'hDEAD_BEEF, 1);
        applyStimulus("wr_idle",   0,0,0, 0, 0, 0, 0, 0, 3'b000,              3'b000,0,1, 32'h8400_0020, 32'hDEAD_BEEF, 1);

        // Back-to-back writes: WWAIT, WRITEP, WENABLEP, WRITE, WENABLE, IDLE.
        applyStimulus("b2b_wwait",    1,1,0, 32'h8800_0000, 0, 0, 0, 0, 3'b100,
                      3'b000,0,1, 32'h8400_0020, 32'hDEAD_BEEF, 1);
        applyStimulus("b2b_writep",   1,1,1, 32'h8800_0004, 32'h8800_0000, 0, 32'h1111_1111, 0, 3'b100,
                      3'b100,0,1, 32'h8800_0000, 32'h1111_1111, 0);
        applyStimulus("b2b_wenablep", 0,1,1, 0, 32'h8800_0004, 32'h8800_0000, 32'h2222_2222, 0, 3'b000,
                      3'b100,1,1, 32'h8800_0000, 32'h1111_1111, 1);
        applyStimulus("b2b_write2",   0,0,1, 0, 0, 32'h8800_0004, 32'h9999_9999, 32'h2222_2222, 3'b001,
                      3'b100,0,1, 32'h8800_0004, 32'h2222_2222, 0);
        applyStimulus("b2b_wenable",  0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b100,1,1, 32'h8800_0004, 32'h2222_2222, 1);
        applyStimulus("b2b_idle",     0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b000,0,1, 32'h8800_0004, 32'h2222_2222, 1);

        // Write immediately followed by a read: WENABLEP goes to READ.
        applyStimulus("wr_rd_wwait",    1,1,0, 32'h8400_0040, 0, 0, 0, 0, 3'b010,
                      3'b000,0,1, 32'h8800_0004, 32'h2222_2222, 1);
        applyStimulus("wr_rd_writep",   1,0,1, 32'h8000_0080, 32'h8400_0040, 0, 32'hCAFE_F00D, 0, 3'b001,
                      3'b010,0,1, 32'h8400_0040, 32'hCAFE_F00D, 0);
        applyStimulus("wr_rd_wenablep", 0,0,0, 32'h8000_0080, 32'h8000_0080, 32'h8400_0040, 0, 32'hCAFE_F00D, 3'b001,
                      3'b010,1,1, 32'h8400_0040, 32'hCAFE_F00D, 1);
        applyStimulus("wr_rd_read",     0,0,0, 32'h8000_0080, 0, 32'h8000_0080, 0, 0, 3'b001,
                      3'b001,0,0, 32'h8000_0080, 32'hCAFE_F00D, 0);
        applyStimulus("wr_rd_renable",  0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b001,1,0, 32'h8000_0080, 32'hCAFE_F00D, 1);
        applyStimulus("wr_rd_idle",     0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b000,0,0, 32'h8000_0080, 32'hCAFE_F00D, 1);

        // Pipelined reads, then a write straight out of RENABLE.
        applyStimulus("rr_read1",   1,0,0, 32'h8000_0100, 0, 0, 0, 0, 3'b001,
                      3'b001,0,0, 32'h8000_0100, 32'hCAFE_F00D, 0);
        applyStimulus("rr_en1",     0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b001,1,0, 32'h8000_0100, 32'hCAFE_F00D, 1);
        applyStimulus("rr_read2",   1,0,0, 32'h8C00_0200, 0, 0, 0, 0, 3'b100,
                      3'b100,0,0, 32'h8C00_0200, 32'hCAFE_F00D, 0);
        applyStimulus("rr_en2",     0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b100,1,0, 32'h8C00_0200, 32'hCAFE_F00D, 1);
        applyStimulus("rw_wwait",   1,1,0, 32'h8400_0300, 0, 0, 0, 0, 3'b010,
                      3'b000,0,0, 32'h8C00_0200, 32'hCAFE_F00D, 1);
        applyStimulus("rw_setup",   0,0,1, 0, 32'h8400_0300, 0, 32'h5A5A_5A5A, 0, 3'b000,
                      3'b010,0,1, 32'h8400_0300, 32'h5A5A_5A5A, 0);
        applyStimulus("rw_enable",  0,0,0, 0, 0, 0, 0, 0, 3'b000,
                      3'b010,1,1, 32'h8400_0300, 32'h5A5A_5A5A, 1);

        // Reset asserted mid-ENABLE must clear the outputs without waiting for a clock edge.
        @(posedge clk);
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput(mkExp("reset_async_mid_enable", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1));
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // After reset the FSM is idle and serves a fresh read.
        applyStimulus("post_rst_idle",    0,0,0, 32'h8000_0010, 0, 0, 0, 0, 3'b001,  3'b000,0,0, 32'h0, 32'h0, 1);
        applyStimulus("post_rst_read",    1,0,0, 32'h8000_0010, 0, 0, 0, 0, 3'b001,  3'b001,0,0, 32'h8000_0010, 32'h0, 0);
        applyStimulus("post_rst_renable", 0,0,0, 0, 0, 0, 0, 0, 3'b000,              3'b001,1,0, 32'h8000_0010, 32'h0, 1);
        applyStimulus("post_rst_done",    0,0,0, 0, 0, 0, 0, 0, 3'b000,              3'b000,0,0, 32'h8000_0010, 32'h0, 1);

        repeat (3) @(negedge clk);
        #1;
        numChecks++;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, required 0", expQ.size());
        end else begin
            numPassed++;
        end

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
Name: apb_fsm_controller

Overview:
- Sequencing FSM for the AHB-to-APB bridge.
- Consumes the decoded AHB slave-interface outputs: valid, pipelined address/data, registered write flag, and one-hot slave select.
- Drives APB SETUP/ENABLE phases and AHB Hreadyout, inserting wait states so each AHB transfer maps to one two-cycle APB transfer.
- Supports single and back-to-back (pipelined) reads and writes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NSLV, 3, number of APB slaves (width of one-hot select)

Ports:
clk  in  1  bridge clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-low
valid  in  1  current AHB address phase targets bridge (NONSEQ/SEQ, Hreadyin high, in range)
Hwrite  in  1  current AHB address-phase direction
Hwritereg  in  1  Hwrite delayed one cycle
Haddr  in  ADDR_W  current AHB address
Haddr1  in  ADDR_W  Haddr delayed 1 cycle
Haddr2  in  ADDR_W  Haddr delayed 2 cycles
Hwdata  in  DATA_W  current AHB write data
Hwdata1  in  DATA_W  Hwdata delayed 1 cycle
tempselx  in  NSLV  one-hot decoded slave for current Haddr
Pselx  out  NSLV  APB slave select, registered
Penable  out  1  APB enable, registered
Pwrite  out  1  APB direction, registered
Paddr  out  ADDR_W  APB address, registered
Pwdata  out  DATA_W  APB write data, registered
Hreadyout  out  1  AHB ready back to master, registered

Behaviour:
- Reset (rst=0, asynchronous):
  - State=ST_IDLE.
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1.
  - Reset asserted mid-transfer aborts the transfer immediately; no completion cycle.
- States: ST_IDLE, ST_WWAIT, ST_READ, ST_WRITE, ST_WRITEP, ST_RENABLE, ST_WENABLE, ST_WENABLEP.
- Transitions:
  - IDLE: valid&Hwrite -> WWAIT; valid&~Hwrite -> READ; else IDLE.
  - WWAIT (waits one cycle for write data): valid -> WRITEP; else WRITE.
  - READ -> RENABLE.
  - WRITE: valid -> WENABLEP; else WENABLE.
  - WRITEP -> WENABLEP.
  - RENABLE and WENABLE: valid&~Hwrite -> READ; valid&Hwrite -> WWAIT; else IDLE.
  - WENABLEP: Hwritereg&valid -> WRITEP; Hwritereg&~valid -> WRITE; ~Hwritereg -> READ.
- Output updates, registered, selected by next state:
  - Entering READ: Pselx=tempselx, Paddr=Haddr, Pwrite=0, Penable=0, Hreadyout=0.
  - Entering WRITE or WRITEP from WWAIT: Pselx=tempselx of held address, Paddr=Haddr1, Pwdata=Hwdata, Pwrite=1, Penable=0, Hreadyout=0.
  - Entering WRITE or WRITEP from WENABLEP: Paddr=Haddr2, Pwdata=Hwdata1; other outputs as for entry from WWAIT.
  - Entering RENABLE, WENABLE or WENABLEP: Penable=1, Hreadyout=1; Pselx, Paddr, Pwrite, Pwdata held.
  - Entering IDLE or WWAIT: Pselx=0, Penable=0, Hreadyout=1; Paddr, Pwrite, Pwdata held.
  - Self-loop in IDLE: all outputs held.
- The block keeps a registered copy of tempselx captured at the write address phase; write SETUP uses this copy.
- Latency:
  - Read: valid in cycle 0 -> SETUP cycle 1 -> ENABLE cycle 2.
  - Write: valid in cycle 0 -> WWAIT cycle 1 -> SETUP cycle 2 -> ENABLE cycle 3.
- Invariants:
  - Penable=1 only in the cycle immediately after a SETUP cycle with identical Pselx/Paddr/Pwrite.
  - Pselx is one-hot or zero.
  - Hreadyout=0 exactly during SETUP cycles.

Test Plan:
- Reset mid-ENABLE (rst low for 1 cycle) -> all outputs return to reset values asynchronously, state IDLE, Hreadyout=1.
- Single read at 0x8000_0010, tempselx=001 -> cycle1: Pselx=001, Paddr=0x8000_0010, Pwrite=0, Penable=0, Hreadyout=0; cycle2: Penable=1, Hreadyout=1; cycle3: Pselx=0.
- Single write at 0x8400_0020, data 0xDEAD_BEEF -> WWAIT, then SETUP with Pselx=010, Paddr=0x8400_0020, Pwdata=0xDEAD_BEEF, Pwrite=1; ENABLE next cycle; then IDLE.
- Back-to-back writes to 0x8800_0000/0x8800_0004 -> path WWAIT, WRITEP, WENABLEP, WRITE, WENABLE; second SETUP Paddr=0x8800_0004 via Haddr2 with matching Hwdata1.
- Write followed by read, no idle cycle -> WENABLEP -> READ; Pwrite drops to 0; read SETUP carries read address.
- valid=0 throughout with Haddr toggling -> FSM stays IDLE; Pselx=0, Hreadyout=1, Paddr unchanged.
